// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset/trap/redirect/halt control with step INCR_P.
// Optional return-address stack built only with PC_SEQUENCER_RAS_EN defined.
module pc_sequencer #(
  parameter int                      DATA_WIDTH_P   = 32,
  parameter logic [DATA_WIDTH_P-1:0] RESET_VECTOR_P = '0,
  parameter logic [DATA_WIDTH_P-1:0] TRAP_VECTOR_P  = 32'h0000_0100,
  parameter int                      INCR_P         = 4,
  parameter int                      RAS_DEPTH_P    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_ready,
  input  logic                    i_redirect_valid,
  input  logic [DATA_WIDTH_P-1:0] i_redirect_target,
  input  logic                    i_trap,
  input  logic                    i_halt,
  input  logic                    i_call,
  input  logic                    i_ret,
  output logic [DATA_WIDTH_P-1:0] o_count,
  output logic                    o_valid,
  output logic                    o_misaligned,
  output logic                    o_halted,
  output logic                    o_ras_empty
);

  localparam logic [DATA_WIDTH_P-1:0] STEP =
    DATA_WIDTH_P'(INCR_P);
  localparam logic [DATA_WIDTH_P-1:0] MASK =
    DATA_WIDTH_P'(INCR_P - 1);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    HALTED
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [DATA_WIDTH_P-1:0] count;
  logic [DATA_WIDTH_P-1:0] count_n;
  logic [DATA_WIDTH_P-1:0] seq;
  logic                    mis;
  logic                    mis_n;
  logic                    accept;
  logic                    flush;

  assign accept = (state == RUN) && i_ready;
  assign flush  = i_trap || i_redirect_valid;
  assign seq    = count + STEP;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PW = (RAS_DEPTH_P > 1) ? $clog2(RAS_DEPTH_P) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH_P);

  logic [DATA_WIDTH_P-1:0] ras [RAS_DEPTH_P];
  logic [PW-1:0]           ptr;
  logic [PW:0]             cnt;
  logic [PW-1:0]           top_idx;
  logic [PW-1:0]           wr_idx;
  logic [DATA_WIDTH_P-1:0] top;
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign empty   = (cnt == '0);
  assign top_idx = ptr - 1'b1;
  assign top     = ras[top_idx];
  assign pop     = accept && i_ret && !empty && !flush;
  // A call alongside a halt is dropped since the PC does not move.
  assign push    = accept && i_call && !flush && (pop || !i_halt);
  assign wr_idx  = pop ? top_idx : ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (pop && !push) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end else if (push && !pop) begin
      ptr <= ptr + 1'b1;
      if (cnt != FULL) cnt <= cnt + 1'b1;
    end
  end

  // Circular buffer: a push when full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (push) ras[wr_idx] <= seq;
  end

  assign o_ras_empty = empty;
`else
  logic unused_hints;

  assign unused_hints = ^{i_call, i_ret};
  assign o_ras_empty  = 1'b1;
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    mis_n   = 1'b0;
    unique case (state)
      INIT: state_n = RUN;
      RUN, HALTED: begin
        if (i_trap) begin
          count_n = TRAP_VECTOR_P;
          state_n = RUN;
        end else if (i_redirect_valid) begin
          state_n = RUN;
          if (|(i_redirect_target & MASK)) begin
            count_n = TRAP_VECTOR_P;
            mis_n   = 1'b1;
          end else begin
            count_n = i_redirect_target;
          end
        end else if (state == RUN) begin
`ifdef PC_SEQUENCER_RAS_EN
          if (pop) count_n = top;
          else
`endif
          if (i_halt) state_n = HALTED;
          else if (accept) count_n = seq;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      count <= RESET_VECTOR_P;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      mis   <= mis_n;
    end
  end

  assign o_count      = count;
  assign o_valid      = (state == RUN);
  assign o_halted     = (state == HALTED);
  assign o_misaligned = mis;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; stack checks run when
// PC_SEQUENCER_RAS_EN is defined, otherwise the hints must be ignored.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_ready;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_target;
  logic        i_trap;
  logic        i_halt;
  logic        i_call;
  logic        i_ret;
  logic [31:0] o_count;
  logic        o_valid;
  logic        o_misaligned;
  logic        o_halted;
  logic        o_ras_empty;

  int n_chk  = 0;
  int n_pass = 0;

  pc_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_ready           (i_ready),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_target (i_redirect_target),
    .i_trap            (i_trap),
    .i_halt            (i_halt),
    .i_call            (i_call),
    .i_ret             (i_ret),
    .o_count           (o_count),
    .o_valid           (o_valid),
    .o_misaligned      (o_misaligned),
    .o_halted          (o_halted),
    .o_ras_empty       (o_ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    i_redirect_valid  = 1'b1;
    i_redirect_target = t;
    step();
    i_redirect_valid  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    i_ready = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_target = '0;
    i_trap = 1'b0;
    i_halt = 1'b0;
    i_call = 1'b0;
    i_ret = 1'b0;
    repeat (2) step();
    chk("rst_count", o_count, 32'h0);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_halted", {31'b0, o_halted}, 32'h0);
    chk("rst_mis", {31'b0, o_misaligned}, 32'h0);
    chk("rst_ras_empty", {31'b0, o_ras_empty}, 32'h1);

    reset_n = 1'b1;
    i_ready = 1'b1;
    #1;
    chk("init_valid", {31'b0, o_valid}, 32'h0);
    step();
    chk("run_valid", {31'b0, o_valid}, 32'h1);
    chk("seq0", o_count, 32'h0);
    step();
    chk("seq1", o_count, 32'h4);
    step();
    chk("seq2", o_count, 32'h8);
    repeat (2) step();
    chk("seq4", o_count, 32'h10);

    i_ready = 1'b0;
    step();
    chk("stall1", o_count, 32'h10);
    step();
    chk("stall2", o_count, 32'h10);
    redirect(32'h200);
    chk("redir", o_count, 32'h200);
    i_ready = 1'b1;

    redirect(32'h202);
    chk("mis_count", o_count, 32'h100);
    chk("mis_pulse", {31'b0, o_misaligned}, 32'h1);
    step();
    chk("mis_clear", {31'b0, o_misaligned}, 32'h0);
    chk("mis_next", o_count, 32'h104);

    i_trap = 1'b1;
    redirect(32'h300);
    i_trap = 1'b0;
    chk("trap_wins", o_count, 32'h100);
    chk("trap_no_mis", {31'b0, o_misaligned}, 32'h0);

    redirect(32'h40);
    chk("pre_halt", o_count, 32'h40);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    chk("halted", {31'b0, o_halted}, 32'h1);
    chk("halt_valid", {31'b0, o_valid}, 32'h0);
    chk("halt_count", o_count, 32'h40);
    i_call = 1'b1;
    i_ret = 1'b1;
    step();
    i_call = 1'b0;
    i_ret = 1'b0;
    chk("halt_hold", o_count, 32'h40);
    chk("halt_ras", {31'b0, o_ras_empty}, 32'h1);
    redirect(32'h80);
    chk("unhalt_count", o_count, 32'h80);
    chk("unhalt_valid", {31'b0, o_valid}, 32'h1);
    chk("unhalt_flag", {31'b0, o_halted}, 32'h0);

    i_ready = 1'b0;
    i_redirect_valid = 1'b1;
    i_redirect_target = 32'h500;
    reset_n = 1'b0;
    #1;
    chk("async_count", o_count, 32'h0);
    chk("async_valid", {31'b0, o_valid}, 32'h0);
    i_redirect_valid = 1'b0;
    step();
    chk("rst_drop", o_count, 32'h0);
    reset_n = 1'b1;
    i_ready = 1'b1;
    step();
    chk("rerun", o_count, 32'h0);
    step();
    chk("rerun_seq", o_count, 32'h4);

`ifdef PC_SEQUENCER_RAS_EN
    redirect(32'h20);
    i_call = 1'b1;
    step();
    i_call = 1'b0;
    chk("call_pc", o_count, 32'h24);
    chk("call_nonempty", {31'b0, o_ras_empty}, 32'h0);
    redirect(32'h500);
    i_ret = 1'b1;
    step();
    i_ret = 1'b0;
    chk("ret_pc", o_count, 32'h24);
    chk("ret_empty", {31'b0, o_ras_empty}, 32'h1);

    redirect(32'h1000);
    i_call = 1'b1;
    repeat (5) step();
    i_call = 1'b0;
    chk("calls_pc", o_count, 32'h1014);
    i_ret = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("pop%0d", k), o_count, 32'h1014 - 32'(4 * k));
    end
    chk("pop_drained", {31'b0, o_ras_empty}, 32'h1);
    step();
    i_ret = 1'b0;
    chk("ret_on_empty", o_count, 32'h100C);
    chk("still_empty", {31'b0, o_ras_empty}, 32'h1);

    i_call = 1'b1;
    step();
    i_call = 1'b0;
    redirect(32'h2000);
    i_call = 1'b1;
    i_ret = 1'b1;
    step();
    i_call = 1'b0;
    chk("callret_pc", o_count, 32'h1010);
    chk("callret_depth", {31'b0, o_ras_empty}, 32'h0);
    step();
    i_ret = 1'b0;
    chk("callret_pop", o_count, 32'h2004);
    chk("callret_empty", {31'b0, o_ras_empty}, 32'h1);
`else
    redirect(32'h20);
    i_call = 1'b1;
    step();
    i_call = 1'b0;
    chk("noras_call", o_count, 32'h24);
    chk("noras_empty", {31'b0, o_ras_empty}, 32'h1);
    i_ret = 1'b1;
    step();
    i_ret = 1'b0;
    chk("noras_ret", o_count, 32'h28);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
